quad_sqrt: RTL

Iterative fixed-point square-root stage placed directly downstream of the quadratic-sum block. Takes its 29-bit unsigned sum-of-squares (5 integer + 24 fractional bits) and produces the 15-bit magnitude (3 integer + 12 fractional bits), one result bit per cycle. Word-length reduction of the result is a parameter, so the word-length optimisation flow can sweep it. Uses a valid/ready handshake on both sides because each operation takes many cycles.

---
 rtl/quad_sqrt_if.sv | 21 ++
 rtl/quad_sqrt.sv | 103 ++++++++++
 2 files changed

// File: rtl/quad_sqrt_if.sv
// Valid/ready operand and result channels of the iterative square-root stage.
// The master drives the operand and accepts the result; the slave is the root engine.
interface quad_sqrt_if;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] c;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] q;
  logic        exact;

  modport master (
    output in_valid, c, out_ready,
    input  in_ready, out_valid, q, exact
  );

  modport slave (
    input  in_valid, c, out_ready,
    output in_ready, out_valid, q, exact
  );
endinterface

// File: rtl/quad_sqrt.sv
// Restoring digit-by-digit square root of a 5.24 sum-of-squares, one root bit per cycle.
// Produces a 3.12 magnitude whose low fractional bits are cleared according to FWL_Q.
module quad_sqrt #(
  parameter int FWL_Q = 12
) (
  input logic        clk,
  input logic        rstn,
  quad_sqrt_if.slave bus
);

  localparam int DATA_W = 29;
  localparam int RAD_W  = 30;
  localparam int REM_W  = 17;
  localparam int ROOT_W = 15;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [RAD_W-1:0]    rad;
  logic [REM_W-1:0]    rem;
  logic [ROOT_W-1:0]   root;
  logic [3:0]          cnt;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [ROOT_W-1:0]   q_r;
  logic                exact_r;

  logic signed [19:0]  trial;
  logic [REM_W-1:0]    rem_nxt;
  logic [ROOT_W-1:0]   root_nxt;

  // Clears the fractional bits below FWL_Q; FWL_Q = 12 passes the root unchanged.
  function automatic logic [ROOT_W-1:0] trunc_q(input logic [ROOT_W-1:0] r);
    logic [ROOT_W-1:0] mask;
    mask = 15'h7fff << (12 - FWL_Q);
    return r & mask;
  endfunction

  // A negative trial means the next root bit is 0 and the partial remainder is kept.
  always_comb begin
    trial    = signed'({1'b0, rem, rad[RAD_W-1 -: 2]}) - signed'({3'b000, root, 2'b01});
    root_nxt = {root[ROOT_W-2:0], ~trial[19]};
    rem_nxt  = trial[19] ? {rem[REM_W-3:0], rad[RAD_W-1 -: 2]} : trial[REM_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      rad         <= '0;
      rem         <= '0;
      root        <= '0;
      cnt         <= '0;
      q_r         <= '0;
      exact_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rad        <= {1'b0, bus.c};
            rem        <= '0;
            root       <= '0;
            cnt        <= 4'd14;
            state      <= CALC;
            in_ready_r <= 1'b0;
          end
        end
        CALC: begin
          rad  <= rad << 2;
          rem  <= rem_nxt;
          root <= root_nxt;
          if (cnt == 4'd0) begin
            q_r         <= trunc_q(root_nxt);
            exact_r     <= (rem_nxt == '0);
            state       <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;
  assign bus.exact     = exact_r;

endmodule
